// File: rtl/sha_nonce_scheduler.sv
// rtl/sha_nonce_scheduler.sv - nonce sweep scheduler for a pool of SHA-256 engines
//
// Hands nonces 0..NUM_NONCES-1 to idle engines, one dispatch per cycle with
// lowest-index priority. It parks each engine's result word in a per-engine
// pending slot and writes the slots back one per cycle to output_addr + nonce,
// also with lowest-index priority, so memory ends up ordered by nonce whatever
// order the engines finish in.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   start              begin a sweep (only looked at while idle)
//   output_addr[15:0]  base word address, captured when start is accepted
//   done               high while idle
//   eng_start[E-1:0]   one-hot dispatch strobe
//   eng_nonce[31:0]    nonce for the strobed engine, 0 when no strobe is high
//   eng_done[E-1:0]    per-engine completion pulse
//   eng_hash[32E-1:0]  per-engine result words, slice k valid with eng_done[k]
//   mem_we, mem_addr[15:0], mem_write_data[31:0]  result write port
module sha_nonce_scheduler #(
   parameter int NUM_ENGINES = 4,
   parameter int NUM_NONCES  = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [15:0]               output_addr,
   output logic                      done,
   output logic [NUM_ENGINES-1:0]    eng_start,
   output logic [31:0]               eng_nonce,
   input  logic [NUM_ENGINES-1:0]    eng_done,
   input  logic [32*NUM_ENGINES-1:0] eng_hash,
   output logic                      mem_we,
   output logic [15:0]               mem_addr,
   output logic [31:0]               mem_write_data
);

   localparam int TW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
   localparam logic [TW:0] LAST = (TW+1)'(NUM_NONCES);
   localparam logic [TW:0] ONE  = (TW+1)'(1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [TW:0]             next_nonce_q, next_nonce_d;
   logic [TW:0]             written_q, written_d;
   logic [15:0]             base_q, base_d;
   logic [NUM_ENGINES-1:0]  busy_q, busy_d;
   logic [NUM_ENGINES-1:0]  pend_valid_q, pend_valid_d;
   logic [TW-1:0]           tag_q [NUM_ENGINES];
   logic [TW-1:0]           tag_d [NUM_ENGINES];
   logic [31:0]             pend_hash_q [NUM_ENGINES];
   logic [31:0]             pend_hash_d [NUM_ENGINES];

   logic                    run_active;
   logic [NUM_ENGINES-1:0]  disp_oh;
   logic [NUM_ENGINES-1:0]  wb_oh;
   logic [TW-1:0]           wb_tag;
   logic [31:0]             wb_hash;

   // The cycle in which the last write has landed is a dead cycle: no
   // dispatch, no write, just the step back to IDLE.
   assign run_active = (state_q == RUN) && (written_q != LAST);

   // Lowest idle engine gets the next nonce. The loop runs high to low so the
   // last hit, i.e. the lowest index, wins.
   always_comb begin
      disp_oh = '0;
      if (run_active && (next_nonce_q < LAST)) begin
         for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            if (!busy_q[k]) begin
               disp_oh    = '0;
               disp_oh[k] = 1'b1;
            end
         end
      end
   end

   // Lowest pending slot is written back this cycle.
   always_comb begin
      wb_oh   = '0;
      wb_tag  = '0;
      wb_hash = '0;
      if (run_active) begin
         for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            if (pend_valid_q[k]) begin
               wb_oh    = '0;
               wb_oh[k] = 1'b1;
               wb_tag   = tag_q[k];
               wb_hash  = pend_hash_q[k];
            end
         end
      end
   end

   assign done           = (state_q == IDLE);
   assign eng_start      = disp_oh;
   assign eng_nonce      = (|disp_oh) ? {{(32-TW){1'b0}}, next_nonce_q[TW-1:0]} : 32'd0;
   assign mem_we         = |wb_oh;
   assign mem_addr       = mem_we ? (base_q + {{(16-TW){1'b0}}, wb_tag}) : 16'd0;
   assign mem_write_data = wb_hash;

   always_comb begin
      state_d      = state_q;
      next_nonce_d = next_nonce_q;
      written_d    = written_q;
      base_d       = base_q;
      busy_d       = busy_q;
      pend_valid_d = pend_valid_q;
      tag_d        = tag_q;
      pend_hash_d  = pend_hash_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = RUN;
               base_d       = output_addr;
               next_nonce_d = '0;
               written_d    = '0;
               busy_d       = '0;
               pend_valid_d = '0;
            end
         end
         RUN: begin
            if (written_q == LAST) begin
               state_d = IDLE;
            end else begin
               if (|disp_oh) begin
                  next_nonce_d = next_nonce_q + ONE;
               end
               for (int k = 0; k < NUM_ENGINES; k++) begin
                  if (disp_oh[k]) begin
                     busy_d[k] = 1'b1;
                     tag_d[k]  = next_nonce_q[TW-1:0];
                  end
                  // Pulses on an idle engine or on a slot that still holds an
                  // unwritten result are dropped; the first result stays.
                  if (eng_done[k] && busy_q[k] && !pend_valid_q[k]) begin
                     pend_valid_d[k] = 1'b1;
                     pend_hash_d[k]  = eng_hash[32*k +: 32];
                  end
                  // The engine becomes dispatchable again only after its
                  // result has left the slot, so a tag is never overwritten
                  // before it has been used.
                  if (wb_oh[k]) begin
                     pend_valid_d[k] = 1'b0;
                     busy_d[k]       = 1'b0;
                  end
               end
               if (|wb_oh) begin
                  written_d = written_q + ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         next_nonce_q <= '0;
         written_q    <= '0;
         base_q       <= '0;
         busy_q       <= '0;
         pend_valid_q <= '0;
         for (int k = 0; k < NUM_ENGINES; k++) begin
            tag_q[k]       <= '0;
            pend_hash_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         next_nonce_q <= next_nonce_d;
         written_q    <= written_d;
         base_q       <= base_d;
         busy_q       <= busy_d;
         pend_valid_q <= pend_valid_d;
         tag_q        <= tag_d;
         pend_hash_q  <= pend_hash_d;
      end
   end

endmodule

// File: doc/sha_nonce_scheduler.md
# sha_nonce_scheduler

Controller that shares a pool of `NUM_ENGINES` SHA-256 nonce-hash engines across a nonce sweep of `NUM_NONCES` nonces. It sits between the top-level bitcoin hash control and the engine array.
- Issues nonces 0..`NUM_NONCES`-1 to idle engines.
- Collects each engine's 32-bit result word (H0 of the second hash).
- Writes each result to memory at `output_addr + nonce` through a single word-wide write port, regardless of completion order.

## Interface
Parameters:
- `NUM_ENGINES`, default 4: engine count, range 1..16.
- `NUM_NONCES`, default 16: nonces per sweep, range 1..256. Tag width TW = max(1, $clog2(`NUM_NONCES`)).

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `output_addr`  in  16  base word address for results; captured on accepted `start`.
- `done`  out  1  high exactly while in IDLE.
- `eng_start`  out  NUM_ENGINES  one-hot dispatch strobe, at most one bit high per cycle.
- `eng_nonce`  out  32  nonce for the strobed engine, zero-extended from TW bits. Value is 0 when no strobe is high.
- `eng_done`  in  NUM_ENGINES  per-engine one-cycle completion pulse.
- `eng_hash`  in  32*NUM_ENGINES  result words; slice k is `[32k+31:32k]` and is valid while `eng_done[k]` is high.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  16  memory write address.
- `mem_write_data`  out  32  memory write data.

## Operation
- States: IDLE, RUN.
- Internal registers:
  - `next_nonce` (TW+1 bits)
  - `written` (TW+1 bits)
  - `base` (16 bits)
  - per engine: `busy[k]`, `tag[k]` (TW bits), `pend_valid[k]`, `pend_hash[k]` (32 bits).
- IDLE:
  - `done`=1.
  - On `start`=1: `base`←`output_addr`, `next_nonce`←0, `written`←0, all `busy`/`pend_valid` cleared, go to RUN.
- RUN:
  - `done`=0. `start` is ignored.
  - Dispatch (combinational from registers):
    - If `next_nonce` < `NUM_NONCES` and some `busy[k]`=0, select the lowest such k.
    - Drive `eng_start[k]`=1 and `eng_nonce`=`next_nonce`.
    - At the edge: `busy[k]`←1, `tag[k]`←`next_nonce`, `next_nonce`++.
  - Capture:
    - For each k with `eng_done[k]`=1, `busy[k]`=1 and `pend_valid[k]`=0: `pend_valid[k]`←1, `pend_hash[k]`←slice k.
    - All engines are captured in parallel.
  - Ignored capture cases:
    - `eng_done[k]` while `busy[k]`=0 is a spurious pulse and is ignored.
    - `eng_done[k]` while `pend_valid[k]`=1 is a protocol violation and is ignored; the first result is kept.
  - Write-back (combinational from registers):
    - If any `pend_valid`, select the lowest such k.
    - Drive `mem_we`=1, `mem_addr`=`base`+`tag[k]` (16-bit add, wraps mod 2^16), `mem_write_data`=`pend_hash[k]`.
    - At the edge: `pend_valid[k]`←0, `busy[k]`←0, `written`++.
    - When no `pend_valid` is set, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0.
  - An engine is not re-dispatched until its result has been written; `busy[k]` clears on its write edge.
  - When `written` = `NUM_NONCES`, go to IDLE on the next edge. No dispatch or write occurs in that cycle.
- Every nonce is issued exactly once and written exactly once. Memory contents are ordered by nonce, independent of engine completion order.

## Timing
- Reset (async assert, sync use):
  - state=IDLE, `done`=1.
  - `eng_start`=0, `eng_nonce`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0.
  - All `busy`/`pend_valid`=0; counters 0.
- Reset mid-RUN aborts the sweep immediately with no further writes. Engines share `reset_n`.
- `start` accepted at edge t → first `eng_start` in cycle t+1 (first RUN cycle).
- Dispatch rate: one engine per cycle. With N engines all idle, dispatch completes in cycles t+1..t+N.
- Write latency: `eng_done[k]` at cycle c → `mem_we` for that result at cycle c+1 at the earliest. It is later only if lower-index results are pending, since there is one write per cycle with fixed lowest-index priority.
- Re-dispatch: earliest re-dispatch of engine k is the cycle after its write cycle, i.e. c+2.
- Same-cycle events:
  - Dispatch to engine j, write-back of engine k and new captures may all occur in one cycle.
  - An engine freed by a write in cycle c is not eligible for dispatch in cycle c.
- Completion: final write at cycle w → RUN still at w+1 → `done`=1 from w+2.

## Test plan
- N=4, 16 nonces, base 0x0100, engine model returns hash = 0xA5000000|nonce after a fixed 130 cycles. Required:
  - `eng_start` one-hot on engines 0,1,2,3 in cycles 1–4 with nonces 0–3.
  - Memory words 0x0100..0x010F = 0xA5000000..0xA500000F.
  - `done` rises exactly 2 cycles after the 16th write.
- Out-of-order completion with per-nonce random latency 5–200 cycles → each word at `base`+n still equals the hash for nonce n, and there are exactly 16 `mem_we` pulses.
- All 4 engines pulse `eng_done` in the same cycle → four consecutive writes in cycles c+1..c+4, in engine order 0,1,2,3, with no result lost.
- Base 0xFFFE, 4 nonces → writes land at addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Edge cases:
  - `start` pulsed during RUN → no restart and no counter change.
  - `eng_done` on an idle engine → no write.
  - `reset_n` low mid-sweep → `done`=1 and `mem_we`=0 immediately.
  - A new `start` after the reset gives a clean 16-write sweep.
- N=1, 3 nonces → strictly serial operation; each next dispatch occurs exactly 2 cycles after the previous `eng_done`.
